// File: rtl/hist_stat_if.sv
// Histogram RAM read port as seen by the statistics scanner.
// master = scanner (drives enable/address), slave = histogram RAM (returns data).
`timescale 1ns/1ps
interface hist_stat_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 24
);
    logic                 hist_en;
    logic [ADDR_BITS-1:0] hist_addr;
    logic [DATA_BITS-1:0] hist_data;

    modport master (
        output hist_en,
        output hist_addr,
        input  hist_data
    );

    modport slave (
        input  hist_en,
        input  hist_addr,
        output hist_data
    );
endinterface

// File: rtl/hist_stat.sv
// Scans a completed frame histogram: total, mean bin, low/high percentile bins.
// Optional peak tracking is built when HIST_STAT_PEAK_EN is defined.
`timescale 1ns/1ps
module hist_stat #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 24
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [DATA_BITS+ADDR_BITS-1:0] lo_thresh,
    input  logic [DATA_BITS+ADDR_BITS-1:0] hi_thresh,
    hist_stat_if.master                    hist,
    output logic                           busy,
    output logic                           done,
    output logic [DATA_BITS+ADDR_BITS-1:0] total,
    output logic [ADDR_BITS-1:0]           mean_bin,
    output logic [ADDR_BITS-1:0]           lo_bin,
    output logic [ADDR_BITS-1:0]           hi_bin,
    output logic [ADDR_BITS-1:0]           peak_bin,
    output logic [DATA_BITS-1:0]           peak_cnt
);
    localparam int TW = DATA_BITS + ADDR_BITS;
    localparam int WW = DATA_BITS + 2 * ADDR_BITS;

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DRAIN, S_DIV, S_DONE} state_t;

    state_t               state_reg;
    logic                 en_reg;
    logic [ADDR_BITS-1:0] addr_reg;
    logic                 vld_reg;
    logic [ADDR_BITS-1:0] idx_reg;
    logic [TW-1:0]        lo_thr_reg;
    logic [TW-1:0]        hi_thr_reg;
    logic [TW-1:0]        cum_reg;
    logic [WW-1:0]        wsum_reg;
    logic                 lo_found_reg;
    logic                 hi_found_reg;
    logic [ADDR_BITS-1:0] lo_acc_reg;
    logic [ADDR_BITS-1:0] hi_acc_reg;
    logic [WW-1:0]        rem_reg;
    logic [WW-1:0]        dsr_reg;
    logic [ADDR_BITS-1:0] quo_reg;
    logic [ADDR_BITS-1:0] cnt_reg;
    logic                 done_reg;
    logic [TW-1:0]        total_reg;
    logic [ADDR_BITS-1:0] mean_reg;
    logic [ADDR_BITS-1:0] lo_reg;
    logic [ADDR_BITS-1:0] hi_reg;

    logic [TW-1:0]        cum_next;
    logic [WW-1:0]        wsum_next;

    // Read data lags the address by one cycle, so idx_reg names the bin in hist_data.
    always_comb begin
        cum_next  = cum_reg + TW'(hist.hist_data);
        wsum_next = wsum_reg + WW'(idx_reg) * WW'(hist.hist_data);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            en_reg       <= 1'b0;
            addr_reg     <= '0;
            vld_reg      <= 1'b0;
            idx_reg      <= '0;
            lo_thr_reg   <= '0;
            hi_thr_reg   <= '0;
            cum_reg      <= '0;
            wsum_reg     <= '0;
            lo_found_reg <= 1'b0;
            hi_found_reg <= 1'b0;
            lo_acc_reg   <= '0;
            hi_acc_reg   <= '0;
            rem_reg      <= '0;
            dsr_reg      <= '0;
            quo_reg      <= '0;
            cnt_reg      <= '0;
            done_reg     <= 1'b0;
            total_reg    <= '0;
            mean_reg     <= '0;
            lo_reg       <= '0;
            hi_reg       <= '0;
        end else begin
            vld_reg  <= en_reg;
            idx_reg  <= addr_reg;
            done_reg <= 1'b0;

            if (vld_reg) begin
                cum_reg  <= cum_next;
                wsum_reg <= wsum_next;
                if (!lo_found_reg && cum_next >= lo_thr_reg) begin
                    lo_found_reg <= 1'b1;
                    lo_acc_reg   <= idx_reg;
                end
                if (!hi_found_reg && cum_next >= hi_thr_reg) begin
                    hi_found_reg <= 1'b1;
                    hi_acc_reg   <= idx_reg;
                end
            end

            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg    <= S_SCAN;
                        lo_thr_reg   <= lo_thresh;
                        hi_thr_reg   <= hi_thresh;
                        cum_reg      <= '0;
                        wsum_reg     <= '0;
                        lo_found_reg <= 1'b0;
                        hi_found_reg <= 1'b0;
                        lo_acc_reg   <= '0;
                        hi_acc_reg   <= '0;
                        en_reg       <= 1'b1;
                        addr_reg     <= '0;
                    end
                end
                S_SCAN: begin
                    if (&addr_reg) begin
                        en_reg    <= 1'b0;
                        state_reg <= S_DRAIN;
                    end else begin
                        addr_reg <= addr_reg + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Final bin lands this cycle; seed the divider from the next-state sums.
                    rem_reg   <= wsum_next;
                    dsr_reg   <= WW'(cum_next) << (ADDR_BITS - 1);
                    quo_reg   <= '0;
                    cnt_reg   <= ADDR_BITS[ADDR_BITS-1:0] - 1'b1;
                    state_reg <= S_DIV;
                end
                S_DIV: begin
                    if (rem_reg >= dsr_reg) begin
                        rem_reg <= rem_reg - dsr_reg;
                        quo_reg <= {quo_reg[ADDR_BITS-2:0], 1'b1};
                    end else begin
                        quo_reg <= {quo_reg[ADDR_BITS-2:0], 1'b0};
                    end
                    dsr_reg <= dsr_reg >> 1;
                    if (cnt_reg == '0) begin
                        state_reg <= S_DONE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                S_DONE: begin
                    total_reg <= cum_reg;
                    mean_reg  <= (cum_reg == '0) ? '0 : quo_reg;
                    lo_reg    <= lo_found_reg ? lo_acc_reg : '1;
                    hi_reg    <= hi_found_reg ? hi_acc_reg : '1;
                    done_reg  <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

`ifdef HIST_STAT_PEAK_EN
    logic [ADDR_BITS-1:0] pk_bin_acc_reg;
    logic [DATA_BITS-1:0] pk_cnt_acc_reg;
    logic [ADDR_BITS-1:0] pk_bin_reg;
    logic [DATA_BITS-1:0] pk_cnt_reg;

    // Strict compare keeps the lowest bin on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pk_bin_acc_reg <= '0;
            pk_cnt_acc_reg <= '0;
            pk_bin_reg     <= '0;
            pk_cnt_reg     <= '0;
        end else begin
            if (state_reg == S_IDLE && start) begin
                pk_bin_acc_reg <= '0;
                pk_cnt_acc_reg <= '0;
            end else if (vld_reg && hist.hist_data > pk_cnt_acc_reg) begin
                pk_bin_acc_reg <= idx_reg;
                pk_cnt_acc_reg <= hist.hist_data;
            end
            if (state_reg == S_DONE) begin
                pk_bin_reg <= pk_bin_acc_reg;
                pk_cnt_reg <= pk_cnt_acc_reg;
            end
        end
    end

    assign peak_bin = pk_bin_reg;
    assign peak_cnt = pk_cnt_reg;
`else
    assign peak_bin = '0;
    assign peak_cnt = '0;
`endif

    assign hist.hist_en   = en_reg;
    assign hist.hist_addr = addr_reg;
    assign busy           = (state_reg != S_IDLE) || done_reg;
    assign done           = done_reg;
    assign total          = total_reg;
    assign mean_bin       = mean_reg;
    assign lo_bin         = lo_reg;
    assign hi_bin         = hi_reg;
endmodule

// File: tb/tb_hist_stat.sv
// Scoreboard bench for hist_stat: histogram RAM model, expected results queued at start.
`timescale 1ns/1ps
module tb_hist_stat;
    localparam int NB = 256;

    typedef struct {
        logic [31:0] total;
        logic [7:0]  mean;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [7:0]  pbin;
        logic [23:0] pcnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] lo_thresh = '0;
    logic [31:0] hi_thresh = '0;
    logic        busy;
    logic        done;
    logic [31:0] total;
    logic [7:0]  mean_bin;
    logic [7:0]  lo_bin;
    logic [7:0]  hi_bin;
    logic [7:0]  peak_bin;
    logic [23:0] peak_cnt;

    logic [23:0] mem [NB];
    exp_t        sb[$];
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          en_cnt = 0;
    int          done_cnt = 0;

    hist_stat_if #(.ADDR_BITS(8), .DATA_BITS(24)) hif ();

    hist_stat #(.ADDR_BITS(8), .DATA_BITS(24)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .lo_thresh(lo_thresh),
        .hi_thresh(hi_thresh),
        .hist(hif.master),
        .busy(busy),
        .done(done),
        .total(total),
        .mean_bin(mean_bin),
        .lo_bin(lo_bin),
        .hi_bin(hi_bin),
        .peak_bin(peak_bin),
        .peak_cnt(peak_cnt)
    );

    always #5 clk = ~clk;

    // Histogram RAM: registered read, data valid one cycle after enable/address.
    always @(posedge clk) begin
        if (hif.hist_en) hif.hist_data <= mem[hif.hist_addr];
    end

    always @(negedge clk) begin
        if (hif.hist_en) en_cnt <= en_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    function automatic exp_t model(input logic [31:0] lo_t, input logic [31:0] hi_t);
        exp_t e;
        longint cum = 0;
        longint ws = 0;
        bit lf = 0;
        bit hf = 0;
        logic [23:0] mx = '0;
        logic [7:0] mxb = '0;
        e.total = '0; e.mean = '0; e.lo = 8'd255; e.hi = 8'd255; e.pbin = '0; e.pcnt = '0;
        for (int i = 0; i < NB; i++) begin
            cum += longint'(mem[i]);
            ws  += longint'(i) * longint'(mem[i]);
            if (!lf && cum >= longint'(lo_t)) begin lf = 1; e.lo = 8'(i); end
            if (!hf && cum >= longint'(hi_t)) begin hf = 1; e.hi = 8'(i); end
            if (mem[i] > mx) begin mx = mem[i]; mxb = 8'(i); end
        end
        e.total = 32'(cum);
        e.mean  = (cum == 0) ? 8'd0 : 8'(ws / cum);
`ifdef HIST_STAT_PEAK_EN
        e.pbin = mxb;
        e.pcnt = mx;
`endif
        return e;
    endfunction

    // Starts a scan and returns the edge number (edge 0 = start sample) after which done is seen.
    task automatic do_scan(input int restart_at, output int lat);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            start = (k == restart_at);
            if (done) begin lat = k; break; end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_cnt++; if ({busy, done, hif.hist_en} !== 3'b000) $display("FAIL reset_ctl: got %b want 000", {busy, done, hif.hist_en}); else pass_cnt++;
        chk_cnt++; if ({total, mean_bin, lo_bin, hi_bin, peak_bin, peak_cnt, hif.hist_addr} !== '0)
            $display("FAIL reset_res: total=%0d mean=%0d lo=%0d hi=%0d want all 0", total, mean_bin, lo_bin, hi_bin); else pass_cnt++;
        rst_n = 1'b1;
        $display("reset: outputs idle");
    endtask

    task automatic test_histograms();
        exp_t e;
        int lat;
        longint sum;
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < NB; i++) begin
                case (p)
                    0: mem[i] = 24'd1;
                    1: mem[i] = (i == 200) ? 24'd1000 : 24'd0;
                    2: mem[i] = 24'd0;
                    3: mem[i] = (i == 10 || i == 20) ? 24'd500 : 24'd0;
                    default: mem[i] = 24'($urandom_range(0, 65535));
                endcase
            end
            sum = 0;
            for (int i = 0; i < NB; i++) sum += longint'(mem[i]);
            case (p)
                0: begin lo_thresh = 32'd64;  hi_thresh = 32'd192;  end
                1: begin lo_thresh = 32'd1;   hi_thresh = 32'd1000; end
                2: begin lo_thresh = 32'd0;   hi_thresh = 32'd5;    end
                3: begin lo_thresh = 32'd600; hi_thresh = 32'd600;  end
                4: begin lo_thresh = $urandom_range(0, 32'(sum / 2)); hi_thresh = $urandom_range(32'(sum / 2), 32'(sum)); end
                default: begin lo_thresh = $urandom_range(1, 32'(sum)); hi_thresh = 32'(sum) + 32'd1; end
            endcase
            sb.push_back(model(lo_thresh, hi_thresh));
            do_scan(-1, lat);
            e = sb.pop_front();
            chk_cnt++; if (lat !== 266) $display("FAIL p%0d latency: got %0d want 266", p, lat); else pass_cnt++;
            chk_cnt++; if (total !== e.total) $display("FAIL p%0d total: got %0d want %0d", p, total, e.total); else pass_cnt++;
            chk_cnt++; if (mean_bin !== e.mean) $display("FAIL p%0d mean_bin: got %0d want %0d", p, mean_bin, e.mean); else pass_cnt++;
            chk_cnt++; if (lo_bin !== e.lo) $display("FAIL p%0d lo_bin: got %0d want %0d", p, lo_bin, e.lo); else pass_cnt++;
            chk_cnt++; if (hi_bin !== e.hi) $display("FAIL p%0d hi_bin: got %0d want %0d", p, hi_bin, e.hi); else pass_cnt++;
            chk_cnt++; if (peak_bin !== e.pbin || peak_cnt !== e.pcnt)
                $display("FAIL p%0d peak: got %0d/%0d want %0d/%0d", p, peak_bin, peak_cnt, e.pbin, e.pcnt); else pass_cnt++;
            chk_cnt++; if (busy !== 1'b1) $display("FAIL p%0d busy_at_done: got %b want 1", p, busy); else pass_cnt++;
            @(posedge clk); #1;
            chk_cnt++; if (done !== 1'b0 || busy !== 1'b0 || total !== e.total)
                $display("FAIL p%0d hold: done=%b busy=%b total=%0d want 0 0 %0d", p, done, busy, total, e.total); else pass_cnt++;
            $display("scan p%0d: lat=%0d total=%0d mean=%0d lo=%0d hi=%0d peak=%0d/%0d", p, lat, total, mean_bin, lo_bin, hi_bin, peak_bin, peak_cnt);
        end
    endtask

    task automatic test_restart();
        exp_t e;
        int lat;
        int en_base;
        int done_base;
        for (int i = 0; i < NB; i++) mem[i] = 24'(i % 7);
        lo_thresh = 32'd100; hi_thresh = 32'd600;
        repeat (2) @(posedge clk);
        en_base = en_cnt; done_base = done_cnt;
        sb.push_back(model(lo_thresh, hi_thresh));
        do_scan(50, lat);
        e = sb.pop_front();
        chk_cnt++; if (lat !== 266) $display("FAIL restart latency: got %0d want 266", lat); else pass_cnt++;
        chk_cnt++; if (total !== e.total || mean_bin !== e.mean || lo_bin !== e.lo || hi_bin !== e.hi)
            $display("FAIL restart results: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", total, mean_bin, lo_bin, hi_bin, e.total, e.mean, e.lo, e.hi); else pass_cnt++;
        repeat (300) @(posedge clk);
        @(negedge clk);
        chk_cnt++; if (done_cnt - done_base !== 1) $display("FAIL restart done_count: got %0d want 1", done_cnt - done_base); else pass_cnt++;
        chk_cnt++; if (en_cnt - en_base !== NB) $display("FAIL restart en_cycles: got %0d want %0d", en_cnt - en_base, NB); else pass_cnt++;
        $display("restart: lat=%0d dones=%0d en_cycles=%0d", lat, done_cnt - done_base, en_cnt - en_base);
    endtask

    task automatic test_abort();
        exp_t e;
        int lat;
        int done_base;
        for (int i = 0; i < NB; i++) mem[i] = 24'd3;
        lo_thresh = 32'd10; hi_thresh = 32'd700;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (99) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_cnt++; if ({busy, done, hif.hist_en} !== 3'b000) $display("FAIL abort_ctl: got %b want 000", {busy, done, hif.hist_en}); else pass_cnt++;
        chk_cnt++; if ({total, mean_bin, lo_bin, hi_bin, peak_bin, peak_cnt, hif.hist_addr} !== '0)
            $display("FAIL abort_res: total=%0d mean=%0d lo=%0d hi=%0d want all 0", total, mean_bin, lo_bin, hi_bin); else pass_cnt++;
        repeat (3) @(negedge clk);
        done_base = done_cnt;
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        chk_cnt++; if (done_cnt !== done_base) $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt - done_base); else pass_cnt++;
        for (int i = 0; i < NB; i++) mem[i] = 24'($urandom_range(0, 4000));
        lo_thresh = 32'd5000; hi_thresh = 32'd400000;
        sb.push_back(model(lo_thresh, hi_thresh));
        do_scan(-1, lat);
        e = sb.pop_front();
        chk_cnt++; if (lat !== 266) $display("FAIL abort_rescan latency: got %0d want 266", lat); else pass_cnt++;
        chk_cnt++; if (total !== e.total || mean_bin !== e.mean || lo_bin !== e.lo || hi_bin !== e.hi || peak_bin !== e.pbin || peak_cnt !== e.pcnt)
            $display("FAIL abort_rescan results: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", total, mean_bin, lo_bin, hi_bin, e.total, e.mean, e.lo, e.hi); else pass_cnt++;
        $display("abort+rescan: lat=%0d total=%0d mean=%0d lo=%0d hi=%0d", lat, total, mean_bin, lo_bin, hi_bin);
    endtask

    initial begin
        for (int i = 0; i < NB; i++) mem[i] = '0;
        test_reset();
        test_histograms();
        test_restart();
        test_abort();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
